// File: rtl/qtcore_loader_pkg.sv
// Shared definitions for the qtcore scan loader.
//
// Contents:
//   BYTE_W          width of one streamed scan byte
//   loader_state_t  control FSM states of the loader top
package qtcore_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_FLUSH,
    ST_RUN
  } loader_state_t;

endpackage

// File: rtl/qtcore_scan_serdes.sv
// Byte-wide serialiser/deserialiser pair for the qtcore scan chain.
// A byte is loaded in parallel together with the number of its bits that
// belong to the chain (1..8). Each shift sends the current MSB out and
// takes one returned bit in at the LSB end.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   i_load       load i_load_data / i_load_len, clear the capture register
//   i_load_data  outgoing byte, MSB goes out first
//   i_load_len   number of bits of this byte to shift (1..8)
//   i_shift      move one bit this cycle
//   i_ser_in     returned bit from the chain
//   o_ser_out    bit presented to the chain
//   o_last_bit   the bit being shifted now is the last one of the byte
//   o_capture    readback byte including this cycle's returned bit,
//                left aligned and zero padded
module qtcore_scan_serdes
  import qtcore_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [BYTE_W-1:0] i_load_data,
  input  logic [3:0]        i_load_len,
  input  logic              i_shift,
  input  logic              i_ser_in,
  output logic              o_ser_out,
  output logic              o_last_bit,
  output logic [BYTE_W-1:0] o_capture
);

  logic [BYTE_W-1:0] r_tx;
  logic [BYTE_W-1:0] r_rx;
  logic [3:0]        r_cnt;
  logic [3:0]        r_len;
  logic [BYTE_W-1:0] w_rx_next;

  // Transmit and capture registers move together: one bit out of the top
  // of r_tx for every bit that enters the bottom of r_rx. A load restarts
  // both and remembers how many bits this byte carries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx  <= '0;
      r_rx  <= '0;
      r_cnt <= '0;
      r_len <= '0;
    end else if (i_load) begin
      r_tx  <= i_load_data;
      r_rx  <= '0;
      r_cnt <= i_load_len;
      r_len <= i_load_len;
    end else if (i_shift) begin
      r_tx  <= {r_tx[BYTE_W-2:0], 1'b0};
      r_rx  <= {r_rx[BYTE_W-2:0], i_ser_in};
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // The capture output already contains the bit arriving this cycle, so the
  // top can latch a finished byte on the same edge that shifts its last bit.
  // A short final byte sits in the low bits and is moved up to the MSB end.
  always_comb begin
    w_rx_next  = {r_rx[BYTE_W-2:0], i_ser_in};
    o_capture  = w_rx_next << (4'(BYTE_W) - r_len);
    o_ser_out  = r_tx[BYTE_W-1];
    o_last_bit = (r_cnt == 4'd1);
  end

endmodule

// File: rtl/qtcore_scan_loader.sv
// Host-side loader for the qtcore scan / processor-control interface.
// Streams CHAIN_LEN bits from a byte stream MSB-first into the chip scan
// chain while returning the bits shifted out as readback bytes, and can
// release the processor to run until it raises halt.
//
// Optional build macro: QTCORE_LOADER_TIMEOUT_EN
//   defined   -> a run is forcibly ended after RUN_TIMEOUT cycles without
//                halt, and timed_out records it
//   undefined -> a run waits for halt forever, timed_out is constant 0
//
// Ports:
//   clk, rst               system clock, synchronous active-high reset
//   start_load, start_run  one-cycle commands, honoured only when idle
//   in_data/in_valid/in_ready     scan byte input stream
//   out_data/out_valid/out_ready  readback byte output stream
//   scan_en_n, proc_en_n   active-low chip enables (never both low)
//   scan_dout, scan_din    chip scan_in / scan_out
//   halt_in                chip halt
//   busy, done, timed_out  status
module qtcore_scan_loader
  import qtcore_loader_pkg::*;
#(
  parameter int CHAIN_LEN   = 143,
  parameter int RUN_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_run,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              scan_en_n,
  output logic              proc_en_n,
  output logic              scan_dout,
  input  logic              scan_din,
  input  logic              halt_in,
  output logic              busy,
  output logic              done,
  output logic              timed_out
);

  localparam int REM_W = $clog2(CHAIN_LEN + 1);

  loader_state_t     r_state;
  loader_state_t     w_next_state;
  logic [REM_W-1:0]  r_remaining;
  logic [REM_W-1:0]  w_rem_dec;
  logic [BYTE_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_done;

  logic              w_run_accept;
  logic              w_fetch_hs;
  logic              w_last;
  logic              w_stall;
  logic              w_shift;
  logic              w_byte_done;
  logic              w_done_set;
  logic              w_timeout_hit;
  logic              w_timeout_set;
  logic [3:0]        w_byte_len;
  logic              w_ser_out;
  logic [BYTE_W-1:0] w_capture;

  qtcore_scan_serdes u_serdes (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_fetch_hs),
    .i_load_data (in_data),
    .i_load_len  (w_byte_len),
    .i_shift     (w_shift),
    .i_ser_in    (scan_din),
    .o_ser_out   (w_ser_out),
    .o_last_bit  (w_last),
    .o_capture   (w_capture)
  );

  // Datapath qualifiers. A byte may only finish when the readback holding
  // register is free or being emptied this very cycle; otherwise the chain
  // is frozen on that last bit so nothing is lost.
  always_comb begin
    w_run_accept = (r_state == ST_IDLE) && start_run && !start_load;
    w_fetch_hs   = (r_state == ST_FETCH) && in_valid;
    w_stall      = w_last && r_out_valid && !out_ready;
    w_shift      = (r_state == ST_SHIFT) && !w_stall;
    w_byte_done  = w_shift && w_last;
    w_rem_dec    = r_remaining - REM_W'(1);
    if (int'(r_remaining) >= BYTE_W) begin
      w_byte_len = 4'(BYTE_W);
    end else begin
      w_byte_len = 4'(r_remaining);
    end
  end

  // Next-state logic. Loads take priority over runs when both commands
  // arrive together; both end with a single done pulse on return to idle.
  always_comb begin
    w_next_state  = r_state;
    w_done_set    = 1'b0;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_load) begin
          w_next_state = ST_FETCH;
        end else if (w_run_accept) begin
          w_next_state = ST_RUN;
        end
      end
      ST_FETCH: begin
        if (in_valid) begin
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_byte_done) begin
          w_next_state = (w_rem_dec == '0) ? ST_FLUSH : ST_FETCH;
        end
      end
      ST_FLUSH: begin
        if (!r_out_valid || out_ready) begin
          w_next_state = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_in) begin
          w_next_state = ST_IDLE;
          w_done_set   = 1'b1;
        end else if (w_timeout_hit) begin
          w_next_state  = ST_IDLE;
          w_done_set    = 1'b1;
          w_timeout_set = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, remaining-bit counter and done pulse. The counter is loaded with
  // the full chain length when a load begins and only counts down on bits
  // that actually move, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done_set;
      if ((r_state == ST_IDLE) && start_load) begin
        r_remaining <= REM_W'(CHAIN_LEN);
      end else if (w_shift) begin
        r_remaining <= w_rem_dec;
      end
    end
  end

  // Readback holding register. A finished byte overwrites it (the stall
  // above guarantees the previous one was already taken); otherwise it
  // empties on the consumer handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_byte_done) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_capture;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef QTCORE_LOADER_TIMEOUT_EN
  localparam int RUN_CNT_W = (RUN_TIMEOUT > 1) ? $clog2(RUN_TIMEOUT) : 1;

  logic [RUN_CNT_W-1:0] r_run_cnt;
  logic                 r_timed_out;

  // Run watchdog. The count restarts on every accepted run, and the last
  // permitted run cycle is the one where it equals RUN_TIMEOUT-1. The
  // sticky flag is cleared by the next accepted run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt   <= '0;
      r_timed_out <= 1'b0;
    end else if (w_run_accept) begin
      r_run_cnt   <= '0;
      r_timed_out <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_run_cnt <= r_run_cnt + RUN_CNT_W'(1);
      if (w_timeout_set) begin
        r_timed_out <= 1'b1;
      end
    end
  end

  assign w_timeout_hit = (r_run_cnt == RUN_CNT_W'(RUN_TIMEOUT - 1));
  assign timed_out     = r_timed_out;
`else
  assign w_timeout_hit = 1'b0;
  assign timed_out     = 1'b0;
`endif

  // Chip-facing and status outputs are decoded from state so that a reset
  // drops both enables on the very next edge, and the two enables can never
  // be low together.
  always_comb begin
    in_ready  = (r_state == ST_FETCH);
    scan_en_n = !w_shift;
    scan_dout = w_shift ? w_ser_out : 1'b0;
    proc_en_n = (r_state != ST_RUN);
    busy      = (r_state != ST_IDLE);
    done      = r_done;
    out_valid = r_out_valid;
    out_data  = r_out_data;
  end

endmodule

// File: tb/tb_qtcore_scan_loader.sv
// Self-checking bench for qtcore_scan_loader with a 12-bit chain (one full
// byte plus a 4-bit partial byte). The chip is a 12-bit shift register
// that outputs its MSB and shifts scan_dout in when scan_en_n is low.
// Expected scan bits and readback bytes are queued from the stimulus and
// the chip preload, then compared as the DUT produces them.
module tb_qtcore_scan_loader;

  localparam int LEN = 12;
  localparam int TMO = 100;
  localparam int NBYTES = (LEN + 7) / 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_load;
  logic       start_run;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       scan_en_n;
  logic       proc_en_n;
  logic       scan_dout;
  logic       scan_din;
  logic       halt_in;
  logic       busy;
  logic       done;
  logic       timed_out;

  int errors = 0;
  int checks = 0;

  logic [LEN-1:0] chip;
  logic [LEN-1:0] chip_preload;
  logic           chip_load_req;
  logic [LEN-1:0] exp_chip;

  bit [7:0] tx_bytes[$];
  bit [7:0] rb_q[$];
  bit       bit_q[$];
  bit       sb_en;
  bit       bp_window;

  int lows_total;
  int lows_window;
  int proc_lows;
  int done_cnt;
  int hs_cnt;

  qtcore_scan_loader #(
    .CHAIN_LEN   (LEN),
    .RUN_TIMEOUT (TMO)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start_load (start_load),
    .start_run  (start_run),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .scan_en_n  (scan_en_n),
    .proc_en_n  (proc_en_n),
    .scan_dout  (scan_dout),
    .scan_din   (scan_din),
    .halt_in    (halt_in),
    .busy       (busy),
    .done       (done),
    .timed_out  (timed_out)
  );

  always #5 clk = ~clk;

  // Chip model: preload on request, otherwise shift while scan is enabled.
  assign scan_din = chip[LEN-1];
  always @(posedge clk) begin
    if (chip_load_req) begin
      chip <= chip_preload;
    end else if (!scan_en_n) begin
      chip <= {chip[LEN-2:0], scan_dout};
    end
  end

  // Scoreboard monitor on the falling edge: pops an expected bit for every
  // enabled shift and an expected byte for every readback handshake, and
  // keeps the event counters the scenario tasks inspect.
  always @(negedge clk) begin
    bit       eb;
    bit [7:0] ey;
    if (!scan_en_n && !proc_en_n) begin
      errors++;
      $display("[TB] FAIL enables_exclusive: scan_en_n=%b proc_en_n=%b required not both 0", scan_en_n, proc_en_n);
    end
    if (!scan_en_n) begin
      lows_total++;
      if (bp_window) lows_window++;
      if (sb_en) begin
        checks++;
        if (bit_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL scan_bit_extra: shift seen with no bit expected, scan_dout=%b", scan_dout);
        end else begin
          eb = bit_q.pop_front();
          if (scan_dout !== eb) begin
            errors++;
            $display("[TB] FAIL scan_bit: got %b expected %b", scan_dout, eb);
          end
        end
      end
    end
    if (!proc_en_n) proc_lows++;
    if (done === 1'b1) done_cnt++;
    if (in_valid && in_ready) hs_cnt++;
    if (out_valid && out_ready && sb_en) begin
      checks++;
      if (rb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL readback_extra: byte %h with none expected", out_data);
      end else begin
        ey = rb_q.pop_front();
        if (out_data !== ey) begin
          errors++;
          $display("[TB] FAIL readback: got %h expected %h", out_data, ey);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    lows_total  = 0;
    lows_window = 0;
    proc_lows   = 0;
    done_cnt    = 0;
    hs_cnt      = 0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit && !ok; c++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
    tick();
  endtask

  task automatic produce(output bit ok);
    bit got;
    ok = 1'b1;
    foreach (tx_bytes[k]) begin
      in_data  = tx_bytes[k];
      in_valid = 1'b1;
      got      = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
      end
      tick();
      if (!got) ok = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  // Queues the expectations of one load, preloads the chip, issues
  // start_load and streams tx_bytes until done.
  task automatic applyStimulus(input logic [LEN-1:0] preload, output bit ok);
    bit       b;
    bit [7:0] acc;
    bit       ok_p;
    bit       ok_d;
    bit_q.delete();
    rb_q.delete();
    exp_chip = '0;
    acc      = '0;
    for (int i = 0; i < LEN; i++) begin
      b = tx_bytes[i / 8][7 - (i % 8)];
      bit_q.push_back(b);
      exp_chip = {exp_chip[LEN-2:0], b};
      acc[7 - (i % 8)] = preload[LEN - 1 - i];
      if ((i % 8 == 7) || (i == LEN - 1)) begin
        rb_q.push_back(acc);
        acc = '0;
      end
    end
    sb_en         = 1'b1;
    chip_preload  = preload;
    chip_load_req = 1'b1;
    tick();
    chip_load_req = 1'b0;
    clear_counts();
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    produce(ok_p);
    wait_done(400, ok_d);
    ok = ok_p && ok_d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({scan_en_n, proc_en_n, scan_dout, in_ready, out_valid, busy, done, timed_out, out_data} !== 16'hC000) begin
      errors++;
      $display("[TB] FAIL reset_state: en_n=%b%b dout=%b rdy=%b ov=%b busy=%b done=%b to=%b od=%h required 11 0 0 0 0 0 0 00",
               scan_en_n, proc_en_n, scan_dout, in_ready, out_valid, busy, done, timed_out, out_data);
    end
    tick();
  endtask

  task automatic test_load_basic();
    bit ok;
    tx_bytes = '{8'hA5, 8'h3C};
    fork
      applyStimulus(12'hF0D, ok);
      begin
        repeat (6) tick();
        start_run = 1'b1;
        tick();
        start_run = 1'b0;
      end
    join
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL basic_done: load did not complete in budget"); end
    checks++;
    if (chip !== exp_chip) begin errors++; $display("[TB] FAIL basic_chip: chip=%h expected %h", chip, exp_chip); end
    checks++;
    if (lows_total != LEN) begin errors++; $display("[TB] FAIL basic_shift_count: %0d expected %0d", lows_total, LEN); end
    checks++;
    if (hs_cnt != NBYTES) begin errors++; $display("[TB] FAIL basic_handshakes: %0d expected %0d", hs_cnt, NBYTES); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("[TB] FAIL basic_done_pulse: %0d cycles expected 1", done_cnt); end
    checks++;
    if (proc_lows != 0) begin errors++; $display("[TB] FAIL run_ignored_in_load: proc_en_n low %0d cycles expected 0", proc_lows); end
    checks++;
    if (rb_q.size() != 0 || bit_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic_leftover: bytes=%0d bits=%0d expected 0 0", rb_q.size(), bit_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_partial_byte();
    bit ok;
    tx_bytes = '{8'hFF, 8'hB7};
    applyStimulus(12'h5A3, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL partial_done: load did not complete in budget"); end
    checks++;
    if (chip !== 12'hFFB) begin errors++; $display("[TB] FAIL partial_chip: chip=%h expected ffb", chip); end
    checks++;
    if (lows_total != 12) begin errors++; $display("[TB] FAIL partial_shift_count: %0d expected 12", lows_total); end
    checks++;
    if (out_data !== 8'h30) begin errors++; $display("[TB] FAIL partial_last_byte: out_data=%h expected 30", out_data); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit seen;
    tx_bytes  = '{8'h96, 8'hC3};
    out_ready = 1'b0;
    seen      = 1'b0;
    fork
      applyStimulus(12'h7E1, ok);
      begin
        for (int c = 0; c < 200 && !seen; c++) begin
          @(negedge clk);
          if (out_valid) seen = 1'b1;
        end
        bp_window = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        out_ready = 1'b1;
        bp_window = 1'b0;
      end
    join
    checks++;
    if (!ok || !seen) begin errors++; $display("[TB] FAIL bp_done: load ok=%b first byte seen=%b expected 1 1", ok, seen); end
    checks++;
    if (lows_window != 3) begin errors++; $display("[TB] FAIL bp_stall: %0d shifts while blocked expected 3", lows_window); end
    checks++;
    if (lows_total != LEN) begin errors++; $display("[TB] FAIL bp_shift_count: %0d expected %0d", lows_total, LEN); end
    checks++;
    if (chip !== exp_chip) begin errors++; $display("[TB] FAIL bp_chip: chip=%h expected %h", chip, exp_chip); end
    checks++;
    if (rb_q.size() != 0) begin errors++; $display("[TB] FAIL bp_readback_count: %0d bytes left expected 0", rb_q.size()); end
  endtask

  task automatic test_run();
    bit ok;
    clear_counts();
    halt_in   = 1'b0;
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    repeat (49) tick();
    halt_in = 1'b1;
    wait_done(20, ok);
    halt_in = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL run_done: no done after halt"); end
    checks++;
    if (proc_lows != 50) begin errors++; $display("[TB] FAIL run_length: proc_en_n low %0d cycles expected 50", proc_lows); end
    checks++;
    if (lows_total != 0) begin errors++; $display("[TB] FAIL run_scan_idle: scan_en_n low %0d cycles expected 0", lows_total); end
    checks++;
    if (done_cnt != 1 || timed_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL run_status: done cycles=%0d timed_out=%b expected 1 0", done_cnt, timed_out);
    end
  endtask

  task automatic test_run_immediate();
    bit ok;
    clear_counts();
    halt_in   = 1'b1;
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    wait_done(20, ok);
    halt_in = 1'b0;
    checks++;
    if (!ok || proc_lows != 1) begin
      errors++;
      $display("[TB] FAIL run_immediate: done=%b proc_en_n low %0d cycles expected 1 1", ok, proc_lows);
    end
  endtask

  task automatic test_timeout();
    bit ok;
`ifdef QTCORE_LOADER_TIMEOUT_EN
    clear_counts();
    halt_in   = 1'b0;
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    wait_done(TMO + 50, ok);
    checks++;
    if (!ok || proc_lows != TMO) begin
      errors++;
      $display("[TB] FAIL timeout_length: done=%b proc_en_n low %0d cycles expected 1 %0d", ok, proc_lows, TMO);
    end
    checks++;
    if (timed_out !== 1'b1) begin errors++; $display("[TB] FAIL timeout_flag: timed_out=%b expected 1", timed_out); end
    halt_in   = 1'b1;
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    checks++;
    if (timed_out !== 1'b0) begin errors++; $display("[TB] FAIL timeout_clear: timed_out=%b expected 0", timed_out); end
    wait_done(20, ok);
    halt_in = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL timeout_rerun: no done after halt"); end
`else
    clear_counts();
    halt_in   = 1'b0;
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    repeat (TMO + 20) tick();
    checks++;
    if (proc_en_n !== 1'b0 || done_cnt != 0 || timed_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_timeout: proc_en_n=%b done cycles=%0d timed_out=%b expected 0 0 0", proc_en_n, done_cnt, timed_out);
    end
    halt_in = 1'b1;
    wait_done(20, ok);
    halt_in = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL no_timeout_halt: no done after halt"); end
`endif
  endtask

  task automatic test_reset_midop();
    bit got;
    sb_en     = 1'b0;
    out_ready = 1'b1;
    in_data   = 8'h5A;
    in_valid  = 1'b1;
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (!got || scan_en_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midshift_setup: handshake=%b scan_en_n=%b expected 1 0", got, scan_en_n);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({scan_en_n, proc_en_n, scan_dout, in_ready, out_valid, busy, done, timed_out, out_data} !== 16'hC000) begin
      errors++;
      $display("[TB] FAIL reset_midshift: en_n=%b%b dout=%b rdy=%b ov=%b busy=%b done=%b to=%b od=%h required 11 0 0 0 0 0 0 00",
               scan_en_n, proc_en_n, scan_dout, in_ready, out_valid, busy, done, timed_out, out_data);
    end
    tick();
    halt_in   = 1'b0;
    start_run = 1'b1;
    tick();
    start_run = 1'b0;
    repeat (10) tick();
    checks++;
    if (proc_en_n !== 1'b0) begin errors++; $display("[TB] FAIL midrun_setup: proc_en_n=%b expected 0", proc_en_n); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({scan_en_n, proc_en_n, scan_dout, in_ready, out_valid, busy, done, timed_out, out_data} !== 16'hC000) begin
      errors++;
      $display("[TB] FAIL reset_midrun: en_n=%b%b dout=%b rdy=%b ov=%b busy=%b done=%b to=%b od=%h required 11 0 0 0 0 0 0 00",
               scan_en_n, proc_en_n, scan_dout, in_ready, out_valid, busy, done, timed_out, out_data);
    end
    tick();
  endtask

  // Hard stop in case a scenario wedges outside its own bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    start_load    = 1'b0;
    start_run     = 1'b0;
    in_data       = 8'h00;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    halt_in       = 1'b0;
    chip_preload  = '0;
    chip_load_req = 1'b0;
    sb_en         = 1'b0;
    bp_window     = 1'b0;
    clear_counts();

    test_reset();
    test_load_basic();
    test_partial_byte();
    test_backpressure();
    test_run();
    test_run_immediate();
    test_timeout();
    test_reset_midop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
